iir_rect_sum: RTL and testbench

IIR_RECT_SUM -- requirements
Module: iir_rect_sum

---
 rtl/iir_rect_sum.sv | 157 +++++++++++++++
 tb/tb_iir_rect_sum.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/iir_rect_sum.sv
// Rectangle pixel sum from an integral image: reads up to four corners (D, B, C, A)
// and returns D - B - C + A. Define IIR_BOUND_CHECK_EN to reject out-of-frame rectangles.
module iir_rect_sum #(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int ADDR_W = 17,
    parameter int DATA_W = 25
) (
    input  logic              iClk,
    input  logic              iReset_n,
    input  logic              iStart,
    input  logic [8:0]        iX,
    input  logic [7:0]        iY,
    input  logic [8:0]        iW,
    input  logic [7:0]        iH,
    output logic              oRd_en,
    output logic [ADDR_W-1:0] oRd_addr,
    input  logic              iRd_valid,
    input  logic [DATA_W-1:0] iRd_data,
    output logic [DATA_W-1:0] oSum,
    output logic              oValid,
    output logic              oErr,
    output logic              oBusy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    // Corner encoding: bit0 = left column (X-1), bit1 = upper row (Y-1).
    localparam logic [1:0] C_D = 2'd0;
    localparam logic [1:0] C_A = 2'd3;

    state_t             state_q, state_d;
    logic [1:0]         corner_q, corner_d;
    logic [8:0]         x_q, x_d, w_q, w_d;
    logic [7:0]         y_q, y_d, h_q, h_d;
    logic [DATA_W-1:0]  acc_q, acc_d, sum_q, sum_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               rd_en_q, rd_en_d, valid_q, valid_d;
    logic               err_q, err_d, errp_q, errp_d;
    logic               oob;
    logic               cur_real, nxt_real;
    logic [ADDR_W-1:0]  row, col;

    // A corner on column -1 or row -1 reads as zero and is skipped.
    function automatic logic corner_real(input logic [1:0] c, input logic [8:0] x,
                                         input logic [7:0] y);
        return !(c[0] && x == 9'd0) && !(c[1] && y == 8'd0);
    endfunction

`ifdef IIR_BOUND_CHECK_EN
    assign oob = (int'(iX) + int'(iW) > IMG_W) || (int'(iY) + int'(iH) > IMG_H);
`else
    assign oob = 1'b0;
`endif

    assign cur_real = corner_real(corner_q, x_q, y_q);
    assign nxt_real = corner_real(corner_d, x_d, y_d);

    always_comb begin
        col = corner_d[0] ? ADDR_W'(x_d) - ADDR_W'(1)
                          : ADDR_W'(x_d) + ADDR_W'(w_d) - ADDR_W'(1);
        row = corner_d[1] ? ADDR_W'(y_d) - ADDR_W'(1)
                          : ADDR_W'(y_d) + ADDR_W'(h_d) - ADDR_W'(1);
    end

    always_comb begin
        state_d  = state_q;
        corner_d = corner_q;
        x_d      = x_q;
        y_d      = y_q;
        w_d      = w_q;
        h_d      = h_q;
        acc_d    = acc_q;
        errp_d   = errp_q;
        case (state_q)
            IDLE: if (iStart) begin
                x_d      = iX;
                y_d      = iY;
                w_d      = iW;
                h_d      = iH;
                acc_d    = '0;
                corner_d = C_D;
                errp_d   = 1'b0;
                if (iW == 9'd0 || iH == 8'd0) begin
                    state_d = DONE;
                end else if (oob) begin
                    state_d = DONE;
                    errp_d  = 1'b1;
                end else begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (cur_real)            state_d = WAIT;
                else if (corner_q == C_A) state_d = DONE;
                else                     corner_d = corner_q + 2'd1;
            end
            WAIT: if (iRd_valid) begin
                // D and A add; B and C subtract.
                acc_d = (corner_q[0] == corner_q[1]) ? acc_q + iRd_data : acc_q - iRd_data;
                if (corner_q == C_A) begin
                    state_d = DONE;
                end else begin
                    state_d  = ISSUE;
                    corner_d = corner_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        rd_en_d = (state_d == ISSUE) && nxt_real;
        addr_d  = rd_en_d ? row * ADDR_W'(IMG_W) + col : addr_q;
        valid_d = (state_d == DONE);
        err_d   = valid_d && errp_d;
        sum_d   = valid_d ? acc_d : sum_q;
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q  <= IDLE;
            corner_q <= C_D;
            x_q      <= '0;
            y_q      <= '0;
            w_q      <= '0;
            h_q      <= '0;
            acc_q    <= '0;
            sum_q    <= '0;
            addr_q   <= '0;
            rd_en_q  <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            errp_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            corner_q <= corner_d;
            x_q      <= x_d;
            y_q      <= y_d;
            w_q      <= w_d;
            h_q      <= h_d;
            acc_q    <= acc_d;
            sum_q    <= sum_d;
            addr_q   <= addr_d;
            rd_en_q  <= rd_en_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            errp_q   <= errp_d;
        end
    end

    assign oRd_en   = rd_en_q;
    assign oRd_addr = addr_q;
    assign oSum     = sum_q;
    assign oValid   = valid_q;
    assign oErr     = err_q;
    assign oBusy    = (state_q != IDLE);

endmodule

// File: tb/tb_iir_rect_sum.sv
// Directed bench for iir_rect_sum: all-ones image behind a latency-1 memory,
// so ii(x,y) = (x+1)(y+1). Expected values are hand-derived per step.
module tb_iir_rect_sum;

    localparam int IMG_W  = 320;
    localparam int ADDR_W = 17;
    localparam int DATA_W = 25;

    logic              iClk = 1'b0;
    logic              iReset_n = 1'b0;
    logic              iStart = 1'b0;
    logic [8:0]        iX = '0, iW = '0;
    logic [7:0]        iY = '0, iH = '0;
    logic              oRd_en, oValid, oErr, oBusy;
    logic [ADDR_W-1:0] oRd_addr;
    logic [DATA_W-1:0] oSum, iRd_data;
    logic              iRd_valid;
    logic              mdl_valid = 1'b0, inj_valid = 1'b0;
    logic [DATA_W-1:0] mdl_data = '0;

    int total = 0, bad = 0;
    int nreads = 0;
    int addr_log [0:255];
    int lat, base, got_sum, got_err;

    assign iRd_valid = mdl_valid | inj_valid;
    assign iRd_data  = mdl_data;

    iir_rect_sum #(.IMG_W(IMG_W), .IMG_H(240), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .iClk(iClk), .iReset_n(iReset_n), .iStart(iStart),
        .iX(iX), .iY(iY), .iW(iW), .iH(iH),
        .oRd_en(oRd_en), .oRd_addr(oRd_addr),
        .iRd_valid(iRd_valid), .iRd_data(iRd_data),
        .oSum(oSum), .oValid(oValid), .oErr(oErr), .oBusy(oBusy)
    );

    always #5 iClk = ~iClk;

    // Memory model: read strobe seen at an edge returns data for exactly the next cycle.
    always @(posedge iClk) begin
        logic            en;
        logic [ADDR_W-1:0] a;
        en = oRd_en;
        a  = oRd_addr;
        if (en) begin
            addr_log[nreads % 256] = int'(a);
            nreads++;
        end
        #1;
        mdl_valid = en;
        mdl_data  = DATA_W'(((int'(a) % IMG_W) + 1) * ((int'(a) / IMG_W) + 1));
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse iStart over one edge (edge k), then watch for oValid; lat = n for cycle k+n.
    task automatic run_req(input int x, input int y, input int w, input int h,
                           input bit mid_start);
        @(posedge iClk); #1;
        base = nreads;
        iX = 9'(x); iY = 8'(y); iW = 9'(w); iH = 8'(h);
        iStart = 1'b1;
        @(posedge iClk); #1;
        iStart = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge iClk);
            if (n == 1) chk("busy_after_start", int'(oBusy), 1);
            if (mid_start && n == 3) begin
                iX = 9'd0; iY = 8'd0; iW = 9'd1; iH = 8'd1; iStart = 1'b1;
            end
            if (mid_start && n == 4) iStart = 1'b0;
            if (oValid) begin
                lat = n;
                got_sum = int'(oSum);
                got_err = int'(oErr);
                break;
            end
        end
        if (lat < 0) chk("timeout_valid", 0, 1);
        @(negedge iClk);
        chk("valid_one_cycle", int'(oValid), 0);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_rd_en", int'(oRd_en), 0);
        chk("rst_valid", int'(oValid), 0);
        chk("rst_err",   int'(oErr),   0);
        chk("rst_busy",  int'(oBusy),  0);
        chk("rst_sum",   int'(oSum),   0);
        chk("rst_addr",  int'(oRd_addr), 0);
        #20 iReset_n = 1'b1;

        // Interior rectangle: four reads, D B C A
        run_req(10, 5, 24, 24, 1'b0);
        chk("int_sum",   got_sum, 576);
        chk("int_lat",   lat, 9);
        chk("int_err",   got_err, 0);
        chk("int_reads", nreads - base, 4);
        chk("int_addrD", addr_log[base % 256],       28*320 + 33);
        chk("int_addrB", addr_log[(base + 1) % 256], 28*320 + 9);
        chk("int_addrC", addr_log[(base + 2) % 256], 4*320 + 33);
        chk("int_addrA", addr_log[(base + 3) % 256], 4*320 + 9);
        repeat (3) @(negedge iClk);
        chk("sum_holds", int'(oSum), 576);
        chk("idle_busy", int'(oBusy), 0);

        // Origin corner: only D is read
        run_req(0, 0, 24, 24, 1'b0);
        chk("org_sum",   got_sum, 576);
        chk("org_lat",   lat, 6);
        chk("org_reads", nreads - base, 1);
        chk("org_addr",  addr_log[base % 256], 7383);

        // Left edge: D and C read, B and A skipped
        run_req(0, 5, 24, 24, 1'b0);
        chk("left_sum",   got_sum, 576);
        chk("left_lat",   lat, 7);
        chk("left_reads", nreads - base, 2);

        // Small rectangle: 2x3 pixels
        run_req(1, 1, 2, 3, 1'b0);
        chk("small_sum",   got_sum, 6);
        chk("small_lat",   lat, 9);
        chk("small_reads", nreads - base, 4);
        chk("small_addrD", addr_log[base % 256], 962);

        // Empty rectangles
        run_req(10, 5, 0, 24, 1'b0);
        chk("w0_sum",   got_sum, 0);
        chk("w0_lat",   lat, 1);
        chk("w0_err",   got_err, 0);
        chk("w0_reads", nreads - base, 0);
        run_req(10, 5, 24, 0, 1'b0);
        chk("h0_sum",   got_sum, 0);
        chk("h0_lat",   lat, 1);
        chk("h0_reads", nreads - base, 0);

`ifdef IIR_BOUND_CHECK_EN
        run_req(300, 5, 24, 24, 1'b0);
        chk("oob_sum",   got_sum, 0);
        chk("oob_err",   got_err, 1);
        chk("oob_lat",   lat, 1);
        chk("oob_reads", nreads - base, 0);
`endif

        // Start while busy is ignored
        run_req(10, 5, 24, 24, 1'b1);
        chk("busy_start_sum",   got_sum, 576);
        chk("busy_start_lat",   lat, 9);
        chk("busy_start_reads", nreads - base, 4);
        repeat (4) @(negedge iClk);
        chk("busy_start_no_extra", int'(oValid) + int'(oBusy), 0);

        // Reset in WAIT after the second read
        @(posedge iClk); #1;
        base = nreads;
        iX = 9'd10; iY = 8'd5; iW = 9'd24; iH = 8'd24; iStart = 1'b1;
        @(posedge iClk); #1;
        iStart = 1'b0;
        repeat (4) @(negedge iClk);
        chk("pre_rst_reads", nreads - base, 2);
        iReset_n = 1'b0;
        #1;
        chk("mid_rst_rd_en", int'(oRd_en), 0);
        chk("mid_rst_busy",  int'(oBusy),  0);
        chk("mid_rst_sum",   int'(oSum),   0);
        chk("mid_rst_addr",  int'(oRd_addr), 0);
        chk("mid_rst_valid", int'(oValid) + int'(oErr), 0);
        @(negedge iClk);
        iReset_n = 1'b1;
        @(posedge iClk); #1;
        inj_valid = 1'b1;
        @(posedge iClk); #1;
        inj_valid = 1'b0;
        repeat (2) @(negedge iClk);
        chk("stale_valid", int'(oValid), 0);
        chk("stale_busy",  int'(oBusy),  0);
        chk("stale_sum",   int'(oSum),   0);
        run_req(10, 5, 24, 24, 1'b0);
        chk("post_rst_sum",   got_sum, 576);
        chk("post_rst_lat",   lat, 9);
        chk("post_rst_reads", nreads - base, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
